// File: rtl/dsp_share_pkg.sv
// Shared widths and defaults for the DSP-sharing front end.
package dsp_share_pkg;

  localparam int unsigned A_W         = 18;
  localparam int unsigned C_W         = 48;
  localparam int unsigned P_W         = 48;
  localparam int unsigned DEF_LATENCY = 4;

endpackage

// File: rtl/dsp_share_arbiter_if.sv
// Requester-side bus of the DSP arbiter: packed operand sets in, shared result out.
interface dsp_share_arbiter_if #(
  parameter int unsigned NREQ = 4
);
  import dsp_share_pkg::*;

  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*A_W-1:0] req_a;
  logic [NREQ*A_W-1:0] req_b;
  logic [NREQ*A_W-1:0] req_d;
  logic [NREQ*C_W-1:0] req_c;
  logic [NREQ-1:0]     rsp_valid;
  logic [P_W-1:0]      rsp_p;

  modport master (
    output req_valid, req_a, req_b, req_d, req_c,
    input  req_ready, rsp_valid, rsp_p
  );

  modport slave (
    input  req_valid, req_a, req_b, req_d, req_c,
    output req_ready, rsp_valid, rsp_p
  );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or above ptr (with wrap).
module rr_arbiter #(
  parameter  int unsigned NREQ = 4,
  localparam int unsigned IDW  = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic            advance,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_id
);

  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] cand;
  logic           found;

  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    cand     = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = IDW'((32'(ptr_q) + k) % NREQ);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_id    = cand;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance) begin
      ptr_d = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/dsp_share_arbiter.sv
// Shares one fixed-latency multiply-add slice among NREQ requesters; a tag pipeline
// matching the slice latency steers each result back to the requester that issued it.
module dsp_share_arbiter
  import dsp_share_pkg::*;
#(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned LATENCY = DEF_LATENCY
) (
  input  logic                      clk,
  input  logic                      rst_n,
  dsp_share_arbiter_if.slave        req_if,
  output logic [A_W-1:0]            dsp_a,
  output logic [A_W-1:0]            dsp_b,
  output logic [A_W-1:0]            dsp_d,
  output logic [C_W-1:0]            dsp_c,
  input  logic [P_W-1:0]            dsp_p,
  output logic                      busy
);

  localparam int unsigned IDW  = $clog2(NREQ);
  localparam int unsigned CNTW = $clog2(LATENCY + 1);

  logic [NREQ-1:0]    grant;
  logic [IDW-1:0]     grant_id;
  logic               xfer;
  logic               rsp_fire;
  logic [LATENCY-1:0] tag_vld_q;
  logic [IDW-1:0]     tag_id_q [LATENCY];
  logic [CNTW-1:0]    cnt_q, cnt_d;

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req_if.req_valid),
    .advance  (xfer),
    .grant    (grant),
    .grant_id (grant_id)
  );

  // The grant only ever selects a valid requester, so any grant is a transfer.
  assign req_if.req_ready = grant;
  assign xfer             = |grant;

  always_comb begin
    dsp_a = '0;
    dsp_b = '0;
    dsp_d = '0;
    dsp_c = '0;
    if (xfer) begin
      dsp_a = req_if.req_a[A_W * grant_id +: A_W];
      dsp_b = req_if.req_b[A_W * grant_id +: A_W];
      dsp_d = req_if.req_d[A_W * grant_id +: A_W];
      dsp_c = req_if.req_c[C_W * grant_id +: C_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_vld_q <= '0;
      for (int k = 0; k < LATENCY; k++) begin
        tag_id_q[k] <= '0;
      end
    end else begin
      tag_vld_q[0] <= xfer;
      tag_id_q[0]  <= grant_id;
      for (int k = 1; k < LATENCY; k++) begin
        tag_vld_q[k] <= tag_vld_q[k-1];
        tag_id_q[k]  <= tag_id_q[k-1];
      end
    end
  end

  assign rsp_fire     = tag_vld_q[LATENCY-1];
  assign req_if.rsp_p = dsp_p;

  always_comb begin
    req_if.rsp_valid = '0;
    if (rsp_fire) begin
      req_if.rsp_valid[tag_id_q[LATENCY-1]] = 1'b1;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (xfer && !rsp_fire) begin
      cnt_d = cnt_q + 1'b1;
    end else if (!xfer && rsp_fire) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy = (cnt_q != '0);

  cnt_in_range: assert property (@(posedge clk) disable iff (!rst_n) cnt_q <= CNTW'(LATENCY));

endmodule

// File: tb/tb_dsp_share_arbiter.sv
// Bench for dsp_share_arbiter with a behavioural P = A*(D+B)+C slice and a queue-based model.
module tb_dsp_share_arbiter;
  import dsp_share_pkg::*;

  localparam int unsigned NREQ = 4;
  localparam int unsigned LAT  = DEF_LATENCY;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dsp_share_arbiter_if #(.NREQ(NREQ)) bus ();

  logic [A_W-1:0] dsp_a, dsp_b, dsp_d;
  logic [C_W-1:0] dsp_c;
  logic [P_W-1:0] dsp_p;
  logic           busy;

  dsp_share_arbiter #(
    .NREQ    (NREQ),
    .LATENCY (LAT)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req_if (bus),
    .dsp_a  (dsp_a),
    .dsp_b  (dsp_b),
    .dsp_d  (dsp_d),
    .dsp_c  (dsp_c),
    .dsp_p  (dsp_p),
    .busy   (busy)
  );

  // Attached slice, sharing rst_n.
  logic [P_W-1:0] slice_q [LAT];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LAT; i++) slice_q[i] <= '0;
    end else begin
      slice_q[0] <= P_W'(dsp_a) * (P_W'(dsp_d) + P_W'(dsp_b)) + P_W'(dsp_c);
      for (int i = 1; i < LAT; i++) slice_q[i] <= slice_q[i-1];
    end
  end
  assign dsp_p = slice_q[LAT-1];

  typedef struct {
    int unsigned    id;
    logic [P_W-1:0] p;
    int unsigned    due;
  } pend_t;

  pend_t          pend[$];
  int unsigned    m_ptr;
  int unsigned    cyc;
  int             n_checks;
  int             n_errors;
  int             e_g;
  logic [NREQ-1:0] e_ready, e_rsp;
  logic [P_W-1:0] e_p;
  logic           e_busy;
  logic [A_W-1:0] e_a;
  logic [C_W-1:0] e_c;

  function automatic logic [P_W-1:0] mac(logic [A_W-1:0] a, logic [A_W-1:0] b,
                                         logic [A_W-1:0] d, logic [C_W-1:0] c);
    return P_W'(a) * (P_W'(d) + P_W'(b)) + P_W'(c);
  endfunction

  task automatic set_op(int unsigned i, logic [A_W-1:0] a, logic [A_W-1:0] b,
                        logic [A_W-1:0] d, logic [C_W-1:0] c);
    bus.req_a[A_W*i +: A_W] = a;
    bus.req_b[A_W*i +: A_W] = b;
    bus.req_d[A_W*i +: A_W] = d;
    bus.req_c[C_W*i +: C_W] = c;
  endtask

  task automatic rand_op(int unsigned i);
    set_op(i, A_W'($urandom), A_W'($urandom), A_W'($urandom), C_W'({$urandom, $urandom}));
  endtask

  // Expected behaviour this cycle from the current inputs and outstanding operations.
  task automatic model_eval();
    int unsigned i;
    e_g = -1;
    for (int unsigned k = 0; k < NREQ; k++) begin
      i = (m_ptr + k) % NREQ;
      if (e_g < 0 && bus.req_valid[i]) e_g = int'(i);
    end
    e_ready = '0;
    e_a     = '0;
    e_c     = '0;
    if (e_g >= 0) begin
      e_ready[e_g] = 1'b1;
      e_a          = bus.req_a[A_W*e_g +: A_W];
      e_c          = bus.req_c[C_W*e_g +: C_W];
    end
    e_rsp = '0;
    e_p   = '0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      e_rsp[pend[0].id] = 1'b1;
      e_p               = pend[0].p;
    end
    e_busy = (pend.size() != 0);
  endtask

  task automatic model_commit();
    pend_t n;
    if (e_rsp != '0) void'(pend.pop_front());
    if (e_g >= 0) begin
      n.id  = unsigned'(e_g);
      n.p   = mac(bus.req_a[A_W*e_g +: A_W], bus.req_b[A_W*e_g +: A_W],
                  bus.req_d[A_W*e_g +: A_W], bus.req_c[C_W*e_g +: C_W]);
      n.due = cyc + LAT;
      pend.push_back(n);
      m_ptr = unsigned'(e_g + 1) % NREQ;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic apply_reset();
    rst_n         = 1'b0;
    bus.req_valid = '0;
    pend.delete();
    m_ptr = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc++;
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.req_valid = '0;
    #3;
    n_checks++;
    if (busy !== 1'b0) begin
      n_errors++; $display("FAIL reset_busy_low: got %b expected 0", busy);
    end
    apply_reset();
    #3;
    model_eval();
    n_checks++;
    if (bus.rsp_valid !== 4'b0000) begin
      n_errors++; $display("FAIL reset_rsp_valid: got %b expected 0000", bus.rsp_valid);
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_errors++; $display("FAIL reset_busy: got %b expected 0", busy);
    end
    n_checks++;
    if (dsp_a !== '0 || dsp_c !== '0) begin
      n_errors++; $display("FAIL reset_dsp_zero: got a=%h c=%h expected 0", dsp_a, dsp_c);
    end
    model_commit();
    bus.req_valid = 4'b1010;
    #3;
    model_eval();
    n_checks++;
    if (bus.req_ready !== 4'b0010) begin
      n_errors++; $display("FAIL reset_ready_follows: got %b expected 0010", bus.req_ready);
    end
    bus.req_valid = '0;
  endtask

  task automatic test_single();
    apply_reset();
    set_op(2, 3, 4, 5, 10);
    for (int t = 0; t <= 6; t++) begin
      bus.req_valid = (t == 0) ? 4'b0100 : 4'b0000;
      #3;
      model_eval();
      if (t == 0) begin
        n_checks++;
        if (bus.req_ready !== 4'b0100) begin
          n_errors++; $display("FAIL single_ready: got %b expected 0100", bus.req_ready);
        end
      end
      n_checks++;
      if (bus.rsp_valid !== ((t == 4) ? 4'b0100 : 4'b0000)) begin
        n_errors++; $display("FAIL single_rsp_valid t=%0d: got %b", t, bus.rsp_valid);
      end
      if (t == 4) begin
        n_checks++;
        if (bus.rsp_p !== 48'd37) begin
          n_errors++; $display("FAIL single_rsp_p: got %0d expected 37", bus.rsp_p);
        end
      end
      n_checks++;
      if (busy !== (t >= 1 && t <= 4)) begin
        n_errors++; $display("FAIL single_busy t=%0d: got %b", t, busy);
      end
      model_commit();
    end
  endtask

  task automatic test_all_valid();
    logic [NREQ-1:0] exp;
    apply_reset();
    for (int t = 0; t < 12 + LAT; t++) begin
      bus.req_valid = (t < 12) ? '1 : '0;
      for (int unsigned i = 0; i < NREQ; i++) rand_op(i);
      #3;
      model_eval();
      if (t < 12) begin
        exp = '0;
        exp[t % NREQ] = 1'b1;
        n_checks++;
        if (bus.req_ready !== exp) begin
          n_errors++; $display("FAIL rr_order t=%0d: got %b expected %b", t, bus.req_ready, exp);
        end
      end
      exp = '0;
      if (t >= LAT) exp[(t - LAT) % NREQ] = 1'b1;
      n_checks++;
      if (bus.rsp_valid !== exp) begin
        n_errors++; $display("FAIL rr_rsp t=%0d: got %b expected %b", t, bus.rsp_valid, exp);
      end
      if (e_rsp != '0) begin
        n_checks++;
        if (bus.rsp_p !== e_p) begin
          n_errors++; $display("FAIL rr_rsp_p t=%0d: got %h expected %h", t, bus.rsp_p, e_p);
        end
      end
      n_checks++;
      if (busy !== e_busy) begin
        n_errors++; $display("FAIL rr_busy t=%0d: got %b expected %b", t, busy, e_busy);
      end
      model_commit();
    end
  endtask

  task automatic test_pair();
    apply_reset();
    // A lone grant to requester 1 leaves the pointer at 2.
    bus.req_valid = 4'b0010;
    #3;
    model_eval();
    model_commit();
    for (int t = 0; t < 6 + LAT; t++) begin
      bus.req_valid = (t < 6) ? 4'b1010 : 4'b0000;
      #3;
      model_eval();
      if (t < 6) begin
        n_checks++;
        if (bus.req_ready !== ((t % 2 == 0) ? 4'b1000 : 4'b0010)) begin
          n_errors++; $display("FAIL pair_grant t=%0d: got %b", t, bus.req_ready);
        end
      end
      n_checks++;
      if (bus.rsp_valid !== e_rsp) begin
        n_errors++; $display("FAIL pair_rsp t=%0d: got %b expected %b", t, bus.rsp_valid, e_rsp);
      end
      model_commit();
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    for (int t = 0; t < 6 + LAT; t++) begin
      bus.req_valid = (t < 6) ? 4'b0001 : 4'b0000;
      if (t < 6) set_op(0, 1, 0, A_W'(t + 1), 0);
      #3;
      model_eval();
      if (t < 6) begin
        n_checks++;
        if (bus.req_ready !== 4'b0001) begin
          n_errors++; $display("FAIL b2b_ready t=%0d: got %b expected 0001", t, bus.req_ready);
        end
      end
      n_checks++;
      if (bus.rsp_valid !== ((t >= LAT) ? 4'b0001 : 4'b0000)) begin
        n_errors++; $display("FAIL b2b_rsp t=%0d: got %b", t, bus.rsp_valid);
      end
      if (t >= LAT) begin
        n_checks++;
        if (bus.rsp_p !== P_W'(t - LAT + 1)) begin
          n_errors++; $display("FAIL b2b_rsp_p t=%0d: got %0d expected %0d", t, bus.rsp_p,
                               t - LAT + 1);
        end
      end
      model_commit();
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    for (int t = 0; t < 3; t++) begin
      bus.req_valid = 4'b0111;
      for (int unsigned i = 0; i < NREQ; i++) rand_op(i);
      #3;
      model_eval();
      model_commit();
    end
    bus.req_valid = '0;
    rst_n = 1'b0;
    for (int t = 0; t < 2; t++) begin
      #3;
      n_checks++;
      if (bus.rsp_valid !== 4'b0000 || busy !== 1'b0) begin
        n_errors++; $display("FAIL midrst_hold t=%0d: got rsp=%b busy=%b expected 0", t,
                             bus.rsp_valid, busy);
      end
      @(posedge clk);
      #1;
    end
    rst_n = 1'b1;
    pend.delete();
    m_ptr = 0;
    for (int t = 0; t < 8; t++) begin
      #3;
      model_eval();
      n_checks++;
      if (bus.rsp_valid !== 4'b0000 || busy !== 1'b0) begin
        n_errors++; $display("FAIL midrst_quiet t=%0d: got rsp=%b busy=%b expected 0", t,
                             bus.rsp_valid, busy);
      end
      model_commit();
    end
    bus.req_valid = '1;
    #3;
    model_eval();
    n_checks++;
    if (bus.req_ready !== 4'b0001) begin
      n_errors++; $display("FAIL midrst_ptr: got %b expected 0001", bus.req_ready);
    end
    model_commit();
    bus.req_valid = '0;
  endtask

  task automatic test_idle();
    apply_reset();
    bus.req_valid = 4'b0100;
    #3;
    model_eval();
    model_commit();
    for (int t = 0; t < 20; t++) begin
      bus.req_valid = '0;
      for (int unsigned i = 0; i < NREQ; i++) rand_op(i);
      #3;
      model_eval();
      n_checks++;
      if (dsp_a !== '0 || dsp_b !== '0 || dsp_d !== '0 || dsp_c !== '0) begin
        n_errors++; $display("FAIL idle_dsp t=%0d: got a=%h b=%h d=%h c=%h expected 0", t,
                             dsp_a, dsp_b, dsp_d, dsp_c);
      end
      n_checks++;
      if (bus.rsp_valid !== e_rsp) begin
        n_errors++; $display("FAIL idle_rsp t=%0d: got %b expected %b", t, bus.rsp_valid, e_rsp);
      end
      model_commit();
    end
    bus.req_valid = '1;
    #3;
    model_eval();
    n_checks++;
    if (bus.req_ready !== 4'b1000) begin
      n_errors++; $display("FAIL idle_ptr_held: got %b expected 1000", bus.req_ready);
    end
    model_commit();
    bus.req_valid = '0;
  endtask

  task automatic test_random();
    logic [NREQ-1:0] hold;
    int unsigned     wait_cnt [NREQ];
    apply_reset();
    hold = '0;
    for (int unsigned i = 0; i < NREQ; i++) wait_cnt[i] = 0;
    for (int t = 0; t < 400 + LAT; t++) begin
      // A requester keeps its operands and valid until it is granted.
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (!hold[i]) rand_op(i);
      end
      bus.req_valid = (t < 400) ? (hold | NREQ'($urandom)) : '0;
      #3;
      model_eval();
      n_checks++;
      if (bus.req_ready !== e_ready) begin
        n_errors++; $display("FAIL rand_ready t=%0d: got %b expected %b", t, bus.req_ready,
                             e_ready);
      end
      n_checks++;
      if (bus.rsp_valid !== e_rsp) begin
        n_errors++; $display("FAIL rand_rsp t=%0d: got %b expected %b", t, bus.rsp_valid, e_rsp);
      end
      if (e_rsp != '0) begin
        n_checks++;
        if (bus.rsp_p !== e_p) begin
          n_errors++; $display("FAIL rand_rsp_p t=%0d: got %h expected %h", t, bus.rsp_p, e_p);
        end
      end
      n_checks++;
      if (busy !== e_busy || dsp_a !== e_a || dsp_c !== e_c) begin
        n_errors++; $display("FAIL rand_bus t=%0d: got busy=%b a=%h c=%h expected %b %h %h", t,
                             busy, dsp_a, dsp_c, e_busy, e_a, e_c);
      end
      hold = bus.req_valid & ~e_ready;
      for (int unsigned i = 0; i < NREQ; i++) begin
        wait_cnt[i] = hold[i] ? wait_cnt[i] + 1 : 0;
        if (hold[i]) begin
          n_checks++;
          if (wait_cnt[i] >= NREQ) begin
            n_errors++; $display("FAIL rand_starve req=%0d: waited %0d cycles, limit %0d", i,
                                 wait_cnt[i], NREQ - 1);
          end
        end
      end
      model_commit();
    end
  endtask

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    cyc           = 0;
    m_ptr         = 0;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_d     = '0;
    bus.req_c     = '0;
    test_reset();
    test_single();
    test_all_valid();
    test_pair();
    test_back_to_back();
    test_reset_mid();
    test_idle();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dsp_share_arbiter.md
# dsp_share_arbiter

Round-robin front end that shares one fixed-latency pipelined multiply-add DSP slice among `NREQ` requesters. Each requester presents an operand set (A, B, C, D). The block grants at most one requester per cycle and drives the DSP operand bus. It tracks each in-flight operation's owner in a tag pipeline and routes the DSP result back to the correct requester. It sits between the requester blocks and the DSP slice; the slice itself stays outside this block.

## Interface
Parameters:
- `NREQ`, 4: number of requesters, 2..8.
- `LATENCY`, 4: cycles from operand acceptance to valid result on `dsp_p`; must match the attached slice; ≥1.
- `IDW`, $clog2(NREQ): tag width (derived, not overridden).

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  NREQ  per-requester operand valid.
- `req_ready`  out  NREQ  per-requester accept (one-hot or zero).
- `req_a`  in  NREQ*18  A operands, requester i at [18i+:18].
- `req_b`  in  NREQ*18  B operands.
- `req_d`  in  NREQ*18  D operands.
- `req_c`  in  NREQ*48  C operands.
- `dsp_a`, `dsp_b`, `dsp_d`  out  18 each  operands to slice.
- `dsp_c`  out  48  operand to slice.
- `dsp_p`  in  48  slice result.
- `rsp_valid`  out  NREQ  one-hot result strobe, one cycle.
- `rsp_p`  out  48  result, shared by all requesters.
- `busy`  out  1  any operation in flight.

## Operation
- Arbitration is round-robin with pointer `ptr`.
  - The grant is the first i with `req_valid[i]`, searching from `ptr` upward with wrap.
  - `req_ready` = one-hot grant, combinational from `req_valid` and `ptr`.
  - A transfer occurs when `req_valid[i] & req_ready[i]`.
- On a transfer by g: `ptr` ← (g+1) mod NREQ. With no transfer, `ptr` holds.
- `dsp_*` mux the granted requester's operands. With no grant they drive all zeros.
- Tag pipeline: LATENCY entries of {valid, id}.
  - Entry 0 loads {transfer, g} every cycle.
  - Entry k loads entry k-1.
- `rsp_valid[id]` = valid of entry LATENCY-1. `rsp_p` = `dsp_p` combinationally; it is don't-care when no strobe.
- Responses have no backpressure. Requesters must absorb the strobe in the cycle it occurs.
- In-flight counter `cnt`, range 0..LATENCY.
  - Increments on a transfer.
  - Decrements on a response.
  - Holds when both or neither occur.
- `busy` = (cnt != 0).
- Result ordering per requester and globally equals acceptance order.
- Reset values: `ptr` = 0, all tag valids = 0, `cnt` = 0, `rsp_valid` = 0, `busy` = 0. `req_ready` follows `req_valid` immediately after reset. The slice shares `rst_n`, so no stale results exist.
- Reset mid-operation: all in-flight tags are dropped and no strobes are emitted for them.

## Timing
- Throughput: one operation per cycle, sustained.
- Latency: accept in cycle t → `rsp_valid` and `rsp_p` in cycle t+LATENCY.
- Requester i holding valid with k other requesters competing is granted within k+1 cycles (no starvation).
- Simultaneous accept and response in one cycle are legal; `cnt` is unchanged.
- `cnt` must never exceed LATENCY. An assertion checks this.

## Structure
- Shared package `dsp_share_pkg`:
  - widths A_W=18, C_W=48, P_W=48.
  - default LATENCY=4.
- Sub-module `rr_arbiter` (NREQ): `req`, `advance`, `grant` one-hot, `grant_id`. It holds `ptr` internally.
- Top level holds the operand mux, tag pipeline and counter.

## Test plan
The attached slice computes P = A*(D+B)+C with LATENCY=4.
- Single request: requester 2 with A=3, B=4, D=5, C=10 in cycle 0 → `req_ready`=0b0100 in cycle 0; `rsp_valid`=0b0100 and `rsp_p`=37 in cycle 4; `busy` high in cycles 1–4.
- All four requesters valid continuously from reset → grants in order 0, 1, 2, 3, 0, 1…; each strobe 4 cycles after its grant; `cnt` saturates at 4.
- Requesters 1 and 3 valid, pointer at 2 → grant 3, then 1, then 3; requester 1 never waits more than 2 cycles.
- Back-to-back requests from requester 0 with A=1, B=0, D=k, C=0 for k = 1..6 → consecutive strobes with `rsp_p` = 1..6 in order.
- Assert `rst_n` low while 3 operations are in flight → `rsp_valid`=0, `busy`=0, `ptr`=0; no strobe after release until new traffic.
- No requests for 20 cycles → `dsp_*` = 0, `rsp_valid` = 0, `ptr` unchanged.
